fas_fft_sched: RTL and testbench

- Frame scheduler between the FIR output stream and the 16-point FFT core in the FAS design.
- Packs FIR samples into 16-sample frames in a ping-pong buffer and launches the FFT core on each full frame.
- After each transform, scans the 16 bins for peak magnitude, then updates freq. Asserts done after the last frame.
- Presents fft_valid/freq/done at the FAS top level.

---
 rtl/fas_fft_sched_if.sv | 28 ++
 rtl/fas_fft_sched.sv | 209 ++++++++++++++++++++
 tb/tb_fas_fft_sched.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fas_fft_sched_if.sv
// Bundle between the FAS frame scheduler, the FIR stream, the FFT core and the FAS top level.
// master: the scheduler side; slave: the FIR/core/top side.
interface fas_fft_sched_if #(
   parameter int DW = 16
);
   logic               fir_valid;
   logic [DW-1:0]      fir_d;
   logic               fft_start;
   logic [16*DW-1:0]   fft_x;
   logic               fft_done;
   logic [3:0]         bin_sel;
   logic [DW-1:0]      bin_re;
   logic [DW-1:0]      bin_im;
   logic               fft_valid;
   logic [3:0]         freq;
   logic               done;
   logic               ovf;

   modport master (
      input  fir_valid, fir_d, fft_done, bin_re, bin_im,
      output fft_start, fft_x, bin_sel, fft_valid, freq, done, ovf
   );

   modport slave (
      output fir_valid, fir_d, fft_done, bin_re, bin_im,
      input  fft_start, fft_x, bin_sel, fft_valid, freq, done, ovf
   );
endinterface

// File: rtl/fas_fft_sched.sv
// FAS frame scheduler: packs FIR samples into 16-sample ping-pong frames, launches the FFT
// core per frame, scans the 16 bins for the peak magnitude and reports its index on freq.
// Optional macro FAS_MAG_L1_EN selects |re|+|im| instead of re^2+im^2 as the magnitude.
module fas_fft_sched #(
   parameter int DW         = 16,
   parameter int NUM_FRAMES = 64
) (
   input  logic            clk,
   input  logic            rst,
   fas_fft_sched_if.master bus
);
   localparam int FCW = $clog2(NUM_FRAMES + 1);
`ifdef FAS_MAG_L1_EN
   localparam int MW = DW + 1;
`else
   localparam int MW = 2 * DW + 1;
`endif

   typedef enum logic [1:0] {StIdle, StWait, StScan, StFin} state_e;

   // Fill side
   logic [DW-1:0] buf_q [2][16];
   logic [1:0]    full_q;
   logic          fill_q;
   logic [3:0]    wr_cnt_q;
   logic          ovf_q;
   logic          accept;
   logic          wrap;
   logic          release_buf;

   // FSM side
   state_e         state_q, state_d;
   logic           exec_q, exec_d;
   logic           fft_start_q, fft_start_d;
   logic           fft_valid_q, fft_valid_d;
   logic [3:0]     bin_sel_q, bin_sel_d;
   logic [3:0]     idx_q, idx_d;
   logic [3:0]     freq_q, freq_d;
   logic [MW-1:0]  max_q, max_d;
   logic [MW-1:0]  mag;
   logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
   logic           done_q, done_d;
   logic [1:0]     avail;
   logic           pick;
   logic [16*DW-1:0] fft_x;

   // A sample is taken only while the fill buffer is free and the run is not finished.
   assign accept = bus.fir_valid && !done_q && !full_q[fill_q];
   assign wrap   = accept && (wr_cnt_q == 4'd15);

   // Fill buffers, ownership flags and overflow flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int n = 0; n < 16; n++) begin
               buf_q[b][n] <= '0;
            end
         end
         full_q   <= '0;
         fill_q   <= 1'b0;
         wr_cnt_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (release_buf) begin
            full_q[exec_q] <= 1'b0;
         end
         if (accept) begin
            buf_q[fill_q][wr_cnt_q] <= bus.fir_d;
            wr_cnt_q                <= wr_cnt_q + 4'd1;
            if (wrap) begin
               full_q[fill_q] <= 1'b1;
               fill_q         <= ~fill_q;
            end
         end else if (bus.fir_valid && !done_q) begin
            ovf_q <= 1'b1;
         end
      end
   end

`ifdef FAS_MAG_L1_EN
   logic [DW-1:0] abs_re, abs_im;
   // Unsigned DW-bit result holds |-2^(DW-1)| exactly.
   assign abs_re = bus.bin_re[DW-1] ? (~bus.bin_re + DW'(1)) : bus.bin_re;
   assign abs_im = bus.bin_im[DW-1] ? (~bus.bin_im + DW'(1)) : bus.bin_im;
   assign mag    = {1'b0, abs_re} + {1'b0, abs_im};
`else
   logic signed [2*DW-1:0] re_sx, im_sx, re_sq, im_sq;
   assign re_sx = {{DW{bus.bin_re[DW-1]}}, bus.bin_re};
   assign im_sx = {{DW{bus.bin_im[DW-1]}}, bus.bin_im};
   assign re_sq = re_sx * re_sx;
   assign im_sq = im_sx * im_sx;
   assign mag   = {1'b0, re_sq} + {1'b0, im_sq};
`endif

   // Oldest full buffer, counting one that completes on this very edge.
   always_comb begin
      avail = full_q;
      if (wrap) begin
         avail[fill_q] = 1'b1;
      end
      if (avail == 2'b11) begin
         pick = wrap ? ~fill_q : fill_q;
      end else begin
         pick = avail[1];
      end
   end

   // FSM state and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         exec_q      <= 1'b0;
         fft_start_q <= 1'b0;
         fft_valid_q <= 1'b0;
         bin_sel_q   <= '0;
         idx_q       <= '0;
         freq_q      <= '0;
         max_q       <= '0;
         frame_cnt_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         exec_q      <= exec_d;
         fft_start_q <= fft_start_d;
         fft_valid_q <= fft_valid_d;
         bin_sel_q   <= bin_sel_d;
         idx_q       <= idx_d;
         freq_q      <= freq_d;
         max_q       <= max_d;
         frame_cnt_q <= frame_cnt_d;
         done_q      <= done_d;
      end
   end

   // FSM next state: launch, wait for the core, scan bins, finish.
   always_comb begin
      state_d     = state_q;
      exec_d      = exec_q;
      fft_start_d = 1'b0;
      fft_valid_d = 1'b0;
      bin_sel_d   = bin_sel_q;
      idx_d       = idx_q;
      freq_d      = freq_q;
      max_d       = max_q;
      frame_cnt_d = frame_cnt_q;
      done_d      = done_q;
      release_buf = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (|avail) begin
               exec_d      = pick;
               fft_start_d = 1'b1;
               state_d     = StWait;
            end
         end
         StWait: begin
            if (bus.fft_done) begin
               fft_valid_d = 1'b1;
               bin_sel_d   = '0;
               max_d       = '0;
               idx_d       = '0;
               state_d     = StScan;
            end
         end
         StScan: begin
            // Strict compare: ties keep the lower bin index.
            if (mag > max_q) begin
               max_d = mag;
               idx_d = bin_sel_q;
            end
            if (bin_sel_q == 4'd15) begin
               freq_d      = (mag > max_q) ? bin_sel_q : idx_q;
               release_buf = 1'b1;
               frame_cnt_d = frame_cnt_q + FCW'(1);
               if (frame_cnt_q == FCW'(NUM_FRAMES - 1)) begin
                  done_d  = 1'b1;
                  state_d = StFin;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               bin_sel_d = bin_sel_q + 4'd1;
            end
         end
         StFin: begin
            done_d = 1'b1;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Present the exec buffer to the core; it is not written while owned by the FSM.
   always_comb begin
      fft_x = '0;
      for (int n = 0; n < 16; n++) begin
         fft_x[n*DW +: DW] = buf_q[exec_q][n];
      end
   end

   assign bus.fft_x     = fft_x;
   assign bus.fft_start = fft_start_q;
   assign bus.fft_valid = fft_valid_q;
   assign bus.bin_sel   = bin_sel_q;
   assign bus.freq      = freq_q;
   assign bus.done      = done_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_fas_fft_sched.sv
// Directed bench for fas_fft_sched with a behavioural FFT core (fixed bin table, programmable
// done delay). Expected peak index for the magnitude case depends on FAS_MAG_L1_EN.
module tb_fas_fft_sched;
   localparam int DW = 16;
   localparam int NF = 4;
`ifdef FAS_MAG_L1_EN
   localparam logic [3:0] MagFreq = 4'd4;
`else
   localparam logic [3:0] MagFreq = 4'd7;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;

   fas_fft_sched_if #(.DW(DW)) bus ();

   fas_fft_sched #(.DW(DW), .NUM_FRAMES(NF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Core model: bin table read combinationally, fft_done after done_delay cycles.
   logic [DW-1:0] bre [16];
   logic [DW-1:0] bim [16];
   int            done_delay = 3;
   int            core_cnt;
   logic          core_busy;

   assign bus.bin_re = bre[bus.bin_sel];
   assign bus.bin_im = bim[bus.bin_sel];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         core_cnt     <= 0;
         core_busy    <= 1'b0;
         bus.fft_done <= 1'b0;
      end else begin
         bus.fft_done <= 1'b0;
         if (bus.fft_start) begin
            core_busy <= 1'b1;
            core_cnt  <= done_delay;
         end else if (core_busy) begin
            if (core_cnt <= 1) begin
               bus.fft_done <= 1'b1;
               core_busy    <= 1'b0;
            end else begin
               core_cnt <= core_cnt - 1;
            end
         end
      end
   end

   // Event log: launches (with first sample of the frame) and valid pulses.
   int            n_start = 0;
   int            n_valid = 0;
   logic [DW-1:0] start_log [$];

   always @(posedge clk) begin
      if (rst) begin
         if (bus.fft_start) begin
            n_start <= n_start + 1;
            start_log.push_back(bus.fft_x[DW-1:0]);
         end
         if (bus.fft_valid) begin
            n_valid <= n_valid + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_bins();
      for (int n = 0; n < 16; n++) begin
         bre[n] = '0;
         bim[n] = '0;
      end
   endtask

   task automatic send_frame(input logic [DW-1:0] base, input logic [DW-1:0] step);
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         bus.fir_valid = 1'b1;
         bus.fir_d     = base + DW'(n) * step;
      end
      @(negedge clk);
      bus.fir_valid = 1'b0;
   endtask

   // Full frame: launch latency, frame contents, valid timing, 16-cycle scan, peak index.
   task automatic do_frame(input string tag, input logic [DW-1:0] base,
                           input logic [DW-1:0] step, input logic [3:0] old_f,
                           input logic [3:0] new_f);
      logic [16*DW-1:0] xexp;
      bit               seen;
      for (int n = 0; n < 16; n++) begin
         xexp[n*DW +: DW] = base + DW'(n) * step;
      end
      send_frame(base, step);
      chk({tag, ":start"}, bus.fft_start, 1);
      chk({tag, ":fft_x"}, bus.fft_x, xexp);
      @(negedge clk);
      chk({tag, ":start_pulse"}, bus.fft_start, 0);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (bus.fft_done) seen = 1'b1;
         else @(negedge clk);
      end
      chk({tag, ":fft_done_seen"}, seen, 1);
      if (seen) begin
         chk({tag, ":valid_early"}, bus.fft_valid, 0);
         @(negedge clk);
         chk({tag, ":valid"}, bus.fft_valid, 1);
         chk({tag, ":bin_sel0"}, bus.bin_sel, 0);
         repeat (15) @(negedge clk);
         chk({tag, ":bin_sel15"}, bus.bin_sel, 15);
         chk({tag, ":freq_old"}, bus.freq, old_f);
         @(negedge clk);
         chk({tag, ":freq"}, bus.freq, new_f);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, v0, q0, q1;
      bit seen;
      bus.fir_valid = 1'b0;
      bus.fir_d     = '0;
      clear_bins();

      // Reset state
      #12;
      chk("rst0:fft_start", bus.fft_start, 0);
      chk("rst0:fft_valid", bus.fft_valid, 0);
      chk("rst0:freq", bus.freq, 0);
      chk("rst0:done", bus.done, 0);
      chk("rst0:ovf", bus.ovf, 0);
      chk("rst0:bin_sel", bus.bin_sel, 0);
      chk("rst0:fft_x", bus.fft_x, 0);
      @(negedge clk);
      rst = 1'b1;

      // Single peak at bin 2
      bre[2] = 16'h0400;
      do_frame("single", 16'h0100, 16'h0000, 4'd0, 4'd2);

      // Equal magnitudes at bins 5 and 9 keep the lower index
      clear_bins();
      bre[5] = 16'h0010; bim[5] = 16'h0010;
      bre[9] = 16'h0010; bim[9] = 16'h0010;
      do_frame("tie", 16'h0200, 16'h0001, 4'd2, 4'd5);

      // Most negative real part beats 0x7fff
      clear_bins();
      bre[3] = 16'h8000;
      bre[8] = 16'h7fff;
      do_frame("neg", 16'h0300, 16'h0011, 4'd5, 4'd3);

      // Reset in the middle of a scan, fir_valid held high
      clear_bins();
      bre[4] = 16'h0300; bim[4] = 16'h0300;
      bre[7] = 16'h0500;
      send_frame(16'h0400, 16'h0001);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (bus.fft_valid) seen = 1'b1;
      end
      chk("rst1:valid_seen", seen, 1);
      repeat (5) @(negedge clk);
      chk("rst1:bin_sel_pre", bus.bin_sel, 5);
      chk("rst1:freq_pre", bus.freq, 3);
      bus.fir_valid = 1'b1;
      bus.fir_d     = 16'h0bad;
      #2 rst = 1'b0;
      #1;
      chk("rst1:freq", bus.freq, 0);
      chk("rst1:bin_sel", bus.bin_sel, 0);
      chk("rst1:fft_valid", bus.fft_valid, 0);
      chk("rst1:fft_start", bus.fft_start, 0);
      chk("rst1:done", bus.done, 0);
      chk("rst1:fft_x", bus.fft_x, 0);
      s0 = n_start;
      v0 = n_valid;
      q0 = start_log.size();
      @(negedge clk);
      @(negedge clk);
      bus.fir_valid = 1'b0;
      rst = 1'b1;

      // Magnitude comparison frame after reset; launched exactly once
      do_frame("mag", 16'h0500, 16'h0001, 4'd0, MagFreq);
      chk("mag:starts", n_start - s0, 1);
      chk("mag:log_size", start_log.size() - q0, 1);

      // Ping-pong with a slow core: second frame buffered, third dropped
      clear_bins();
      done_delay = 40;
      q1 = start_log.size();
      for (int n = 0; n < 48; n++) begin
         @(negedge clk);
         if (n == 32) chk("pp:ovf_before", bus.ovf, 0);
         bus.fir_valid = 1'b1;
         if (n < 16)      bus.fir_d = 16'h2000 + DW'(n);
         else if (n < 32) bus.fir_d = 16'h3000 + DW'(n - 16);
         else             bus.fir_d = 16'h4000 + DW'(n - 32);
      end
      @(negedge clk);
      bus.fir_valid = 1'b0;
      chk("pp:ovf", bus.ovf, 1);
      for (int i = 0; i < 400 && (n_valid - v0) < 3; i++) @(negedge clk);
      chk("pp:valids", n_valid - v0, 3);
      repeat (18) @(negedge clk);
      chk("pp:launches", start_log.size() - q1, 2);
      if (start_log.size() >= q1 + 2) begin
         chk("pp:first_frame", start_log[q1], 16'h2000);
         chk("pp:second_frame", start_log[q1 + 1], 16'h3000);
      end
      chk("pp:freq", bus.freq, 0);
      chk("pp:done", bus.done, 0);

      // Last frame completes the run
      done_delay = 3;
      bim[6] = 16'h0100;
      do_frame("last", 16'h0600, 16'h0001, 4'd0, 4'd6);
      chk("fin:done", bus.done, 1);
      chk("fin:starts", n_start - s0, 4);
      chk("fin:valids", n_valid - v0, 4);
      chk("fin:ovf_sticky", bus.ovf, 1);

      // Samples after done are ignored
      send_frame(16'h0700, 16'h0001);
      send_frame(16'h0800, 16'h0001);
      repeat (10) @(negedge clk);
      chk("post:starts", n_start - s0, 4);
      chk("post:done_held", bus.done, 1);
      chk("post:freq_held", bus.freq, 6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
